// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
//   Shared types and geometry for the LED-panel framebuffer write master.
//   fb_op_t            : drawing command opcodes (cmd_op encoding)
//   fb_writer_state_t  : fb_writer control states
//   FB_COLS / FB_ROWS  : panel geometry (64 x 64)
//   FB_ADDR_W          : framebuffer write address width ({row, col})
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_COLS   = 64;
  localparam int FB_ROWS   = 64;
  localparam int FB_ADDR_W = 12;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'b00,
    OP_HLINE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } fb_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } fb_writer_state_t;

endpackage

// File: rtl/fb_writer.sv
// ---------------------------------------------------------------------------
// fb_writer
//   Write-side master for the dual-half 64x64 framebuffer. Takes drawing
//   commands (PIXEL / HLINE / FILL) over valid/ready and expands each into
//   back-to-back single-cycle writes on the framebuffer write port.
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     cmd_valid/cmd_ready   command handshake (ready = state is IDLE)
//     cmd_op                00 PIXEL, 01 HLINE, 10 FILL, 11 reserved
//     cmd_x, cmd_y          start column / row
//     cmd_len               HLINE length minus one
//     cmd_color             pixel value
//     waddr, din, we        framebuffer write port, waddr = {y, x}
//     busy                  high during every write cycle of a command
//     done                  one-cycle pulse with the last write (or ACK)
//
//   The write address register doubles as the iteration counter: it is
//   loaded with the first address at acceptance and stepped until it equals
//   the end address captured at the same time.
// ---------------------------------------------------------------------------
module fb_writer
  import fb_pkg::*;
#(
  parameter int COL_W   = 6,
  parameter int ROW_W   = 6,
  parameter int COLOR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [COL_W-1:0]         cmd_x,
  input  logic [ROW_W-1:0]         cmd_y,
  input  logic [COL_W-1:0]         cmd_len,
  input  logic [COLOR_W-1:0]       cmd_color,
  output logic [COL_W+ROW_W-1:0]   waddr,
  output logic [COLOR_W-1:0]       din,
  output logic                     we,
  output logic                     busy,
  output logic                     done
);

  localparam int ADDR_W = COL_W + ROW_W;

  fb_writer_state_t    state_q, state_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   end_q,   end_d;
  logic [COLOR_W-1:0]  din_q,   din_d;
  logic                we_q,    we_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  fb_op_t              op;
  logic                accept;
  logic [COL_W:0]      xsum;      // one extra bit so x+len overflow is exact
  logic [COL_W-1:0]    hl_end_x;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   next_addr;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign op        = fb_op_t'(cmd_op);

  // Right-edge clip: a line that would run past the last column stops there
  // instead of wrapping onto column 0 / the next row.
  assign xsum      = {1'b0, cmd_x} + {1'b0, cmd_len};
  assign hl_end_x  = xsum[COL_W] ? {COL_W{1'b1}} : xsum[COL_W-1:0];

  assign next_addr = waddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // First/last address of the command being offered on the cmd_* bus.
  always_comb begin
    start_addr = {cmd_y, cmd_x};
    last_addr  = {cmd_y, cmd_x};
    case (op)
      OP_HLINE: last_addr = {cmd_y, hl_end_x};
      OP_FILL: begin
        start_addr = '0;
        last_addr  = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    end_d   = end_q;
    din_d   = din_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_RSVD) begin
            // No writes; waddr/din keep their previous values.
            state_d = ACK;
            done_d  = 1'b1;
          end else begin
            state_d = WRITE;
            waddr_d = start_addr;
            end_d   = last_addr;
            din_d   = cmd_color;
            we_d    = 1'b1;
            busy_d  = 1'b1;
            done_d  = (start_addr == last_addr);
          end
        end
      end

      WRITE: begin
        if (waddr_q == end_q) begin
          state_d = IDLE;
        end else begin
          waddr_d = next_addr;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          done_d  = (next_addr == end_q);
        end
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      end_q   <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      end_q   <= end_d;
      din_q   <= din_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign waddr = waddr_q;
  assign din   = din_q;
  assign we    = we_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_writer : self-checking bench for fb_writer. Each command's expected
// write list is built from plain arithmetic on x/y/len, then checked cycle by
// cycle together with busy/done/cmd_ready and the idle cycle that follows.
// ---------------------------------------------------------------------------
module tb_fb_writer;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [5:0]  cmd_len;
  logic [3:0]  cmd_color;
  logic [11:0] waddr;
  logic [3:0]  din;
  logic        we;
  logic        busy;
  logic        done;

  fb_writer #(.COL_W(6), .ROW_W(6), .COLOR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_len   (cmd_len),
    .cmd_color (cmd_color),
    .waddr     (waddr),
    .din       (din),
    .we        (we),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int last_addr = 0;   // model of the held write-port values
  int last_din  = 0;
  int nx, ny, nc;      // command parked behind a busy one (hold mode)

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command (DUT must be idle, called just after a negedge) and
  // check every cycle through the first idle cycle after it.
  //   junk : while busy, toggle cmd_valid with random fields (must be ignored)
  //   hold : while busy, present PIXEL {nx,ny,nc} with cmd_valid held high
  task automatic run_cmd(input int op, input int x, input int y, input int len,
                         input int color, input bit junk, input bit hold);
    int q[$];
    int n, cyc;
    case (op)
      0: q.push_back(y * 64 + x);
      1: for (int c = x; c <= x + len && c <= 63; c++) q.push_back(y * 64 + c);
      2: for (int a = 0; a < 4096; a++) q.push_back(a);
      default: ;
    endcase
    n   = q.size();
    cyc = (n == 0) ? 1 : n;

    chk("ready_before", int'(cmd_ready), 1);
    cmd_op    = 2'(op);
    cmd_x     = 6'(x);
    cmd_y     = 6'(y);
    cmd_len   = 6'(len);
    cmd_color = 4'(color);
    cmd_valid = 1'b1;
    @(posedge clk);

    for (int k = 1; k <= cyc; k++) begin
      @(negedge clk);
      if (n > 0) begin
        chk("we",    int'(we),    1);
        chk("waddr", int'(waddr), q[k-1]);
        chk("din",   int'(din),   color);
        chk("busy",  int'(busy),  1);
        chk("done",  int'(done),  int'(k == n));
        chk("ready", int'(cmd_ready), 0);
      end else begin
        chk("rsvd_we",    int'(we),    0);
        chk("rsvd_busy",  int'(busy),  0);
        chk("rsvd_done",  int'(done),  1);
        chk("rsvd_ready", int'(cmd_ready), 0);
        chk("rsvd_waddr", int'(waddr), last_addr);
      end
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_x     = 6'(nx);
        cmd_y     = 6'(ny);
        cmd_color = 4'(nc);
      end else if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_x     = 6'($urandom_range(0, 63));
        cmd_y     = 6'($urandom_range(0, 63));
        cmd_len   = 6'($urandom_range(0, 63));
        cmd_color = 4'($urandom_range(0, 15));
      end else begin
        cmd_valid = 1'b0;
      end
    end

    if (n > 0) begin
      last_addr = q[n-1];
      last_din  = color;
    end

    @(negedge clk);
    chk("idle_we",    int'(we),    0);
    chk("idle_busy",  int'(busy),  0);
    chk("idle_done",  int'(done),  0);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_waddr", int'(waddr), last_addr);
    chk("idle_din",   int'(din),   last_din);
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    int op, sel, fills;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_len   = '0;
    cmd_color = '0;
    #12;
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_din",   int'(din),   0);
    chk("rst_we",    int'(we),    0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_cmd(0, 5, 40, 0, 4'hA, 0, 0);        // waddr 2565
    run_cmd(1, 60, 0, 10, 3, 0, 0);          // clipped at column 63
    run_cmd(1, 0, 63, 63, 7, 0, 0);          // full bottom row
    run_cmd(3, 0, 0, 0, 0, 0, 0);            // reserved op
    nx = 17; ny = 9; nc = 4'h6;
    run_cmd(2, 0, 0, 0, 4'hF, 0, 1);         // FILL with PIXEL waiting
    run_cmd(0, nx, ny, 0, nc, 0, 0);
    run_cmd(1, 63, 31, 0, 2, 1, 0);          // single-pixel line at the edge
    run_cmd(1, 10, 32, 63, 9, 1, 0);

    // Reset in the middle of a FILL
    cmd_op = 2'd2; cmd_color = 4'h5; cmd_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("fill100_we",    int'(we),    1);
    chk("fill100_waddr", int'(waddr), 99);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",    int'(we),    0);
    chk("arst_busy",  int'(busy),  0);
    chk("arst_done",  int'(done),  0);
    chk("arst_waddr", int'(waddr), 0);
    chk("arst_din",   int'(din),   0);
    chk("arst_ready", int'(cmd_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("arst_nodone", int'(done), 0);
    end
    rst_n = 1'b1;
    last_addr = 0;
    last_din  = 0;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    run_cmd(0, 33, 12, 0, 4'hC, 0, 0);

    // Random commands
    fills = 0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40)                   op = 0;
      else if (sel < 86)              op = 1;
      else if (sel < 89 && fills < 2) op = 2;
      else                            op = 3;
      if (op == 2) fills++;
      run_cmd(op, $urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 63), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
